// File: rtl/regfile_wb_ctrl.sv
// Register file write-port controller: merges MEM/WB and slow-unit results into
// one registered write per cycle, with a slow-result FIFO and busy scoreboard.
module regfile_wb_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int ZERO_ADDR  = 0,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we_i,
  input  logic [ADDR_W-1:0]    pipe_waddr_i,
  input  logic [DATA_W-1:0]    pipe_wdata_i,
  input  logic                 slow_valid_i,
  output logic                 slow_ready_o,
  input  logic [ADDR_W-1:0]    slow_waddr_i,
  input  logic [DATA_W-1:0]    slow_wdata_i,
  input  logic                 issue_valid_i,
  input  logic [ADDR_W-1:0]    issue_waddr_i,
  output logic [2**ADDR_W-1:0] busy_o,
  output logic                 hold_o,
  output logic                 conflict_o,
  output logic                 wEnable_o,
  output logic [ADDR_W-1:0]    wAddr_o,
  output logic [DATA_W-1:0]    wData_o
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [SW-1:0]     starve_reg;
  logic [NREG-1:0]   busy_reg, busy_next;
  logic              wen_reg, conflict_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              fifo_empty, push, pop, pipe_win;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign fifo_empty   = (count_reg == '0);
  assign slow_ready_o = !rst && (count_reg < CW'(FIFO_DEPTH));
  // Zero-register results are consumed without occupying a slot.
  assign push         = slow_valid_i && slow_ready_o && (slow_waddr_i != ZERO);
  assign hold_o       = (starve_reg >= SW'(STARVE_MAX)) && !fifo_empty;
  assign head_addr    = fifo_addr_mem[rd_ptr_reg];
  assign head_data    = fifo_data_mem[rd_ptr_reg];

  always_comb begin
    pop      = 1'b0;
    pipe_win = 1'b0;
    if (hold_o) begin
      pop = 1'b1;
    end else if (pipe_we_i && (pipe_waddr_i != ZERO)) begin
      pipe_win = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) count_next = count_reg + CW'(1);
    else if (!push && pop) count_next = count_reg - CW'(1);
  end

  // Set beats clear when issue and writeback hit the same register.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign busy_next[gi] =
        (issue_valid_i && (issue_waddr_i != ZERO) && (issue_waddr_i == ADDR_W'(gi))) ||
        (busy_reg[gi] && !(pop && (head_addr == ADDR_W'(gi))));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= slow_waddr_i;
      fifo_data_mem[wr_ptr_reg] <= slow_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      starve_reg   <= '0;
      busy_reg     <= '0;
      wen_reg      <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      conflict_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      if (fifo_empty || pop) starve_reg <= '0;
      else if (starve_reg != SW'(STARVE_MAX)) starve_reg <= starve_reg + SW'(1);
      busy_reg     <= busy_next;
      wen_reg      <= pop || pipe_win;
      waddr_reg    <= pop ? head_addr : (pipe_win ? pipe_waddr_i : '0);
      wdata_reg    <= pop ? head_data : (pipe_win ? pipe_wdata_i : '0);
      conflict_reg <= pipe_win && busy_reg[pipe_waddr_i];
    end
  end

  assign busy_o     = busy_reg;
  assign conflict_o = conflict_reg;
  assign wEnable_o  = wen_reg;
  assign wAddr_o    = waddr_reg;
  assign wData_o    = wdata_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: hand-computed expectations per cycle.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [3:0]  pipe_waddr;
  logic [15:0] pipe_wdata;
  logic        slow_valid;
  logic        slow_ready;
  logic [3:0]  slow_waddr;
  logic [15:0] slow_wdata;
  logic        issue_valid;
  logic [3:0]  issue_waddr;
  logic [15:0] busy;
  logic        hold;
  logic        conflict;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .pipe_we_i(pipe_we), .pipe_waddr_i(pipe_waddr), .pipe_wdata_i(pipe_wdata),
    .slow_valid_i(slow_valid), .slow_ready_o(slow_ready),
    .slow_waddr_i(slow_waddr), .slow_wdata_i(slow_wdata),
    .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr),
    .busy_o(busy), .hold_o(hold), .conflict_o(conflict),
    .wEnable_o(wen), .wAddr_o(waddr), .wData_o(wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [3:0] a, input logic [15:0] d);
    pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic set_slow(input logic v, input logic [3:0] a, input logic [15:0] d);
    slow_valid = v; slow_waddr = a; slow_wdata = d;
  endtask

  task automatic check_wr(input string tag, input logic e, input logic [3:0] a, input logic [15:0] d);
    check({tag, "_we"}, 32'(wen), 32'(e));
    if (e) begin
      check({tag, "_addr"}, 32'(waddr), 32'(a));
      check({tag, "_data"}, 32'(wdata), 32'(d));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_pipe(1'b0, 4'd0, 16'h0);
    set_slow(1'b1, 4'd7, 16'h0001);
    issue_valid = 1'b0; issue_waddr = 4'd0;

    // T1: reset with a slow result offered
    step();
    check("t1_we", 32'(wen), 32'd0);
    check("t1_addr", 32'(waddr), 32'd0);
    check("t1_data", 32'(wdata), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_hold", 32'(hold), 32'd0);
    check("t1_conf", 32'(conflict), 32'd0);
    check("t1_ready", 32'(slow_ready), 32'd0);
    rst = 1'b0;
    set_slow(1'b0, 4'd0, 16'h0);
    step();
    check("t1_nowr", 32'(wen), 32'd0);
    check("t1_ready_up", 32'(slow_ready), 32'd1);

    // T2: plain pipe write, then zero-register write ignored
    set_pipe(1'b1, 4'd3, 16'h1234);
    step();
    check_wr("t2_w3", 1'b1, 4'd3, 16'h1234);
    set_pipe(1'b1, 4'd0, 16'h5555);
    step();
    check_wr("t2_w0", 1'b0, 4'd0, 16'h0);
    set_pipe(1'b0, 4'd0, 16'h0);

    // T3: issue r5, slow result arrives, written one cycle after acceptance
    issue_valid = 1'b1; issue_waddr = 4'd5;
    step();
    check("t3_busy_set", 32'(busy), 32'h0020);
    issue_valid = 1'b0;
    set_slow(1'b1, 4'd5, 16'hBEEF);
    step();
    check("t3_push_nowr", 32'(wen), 32'd0);
    set_slow(1'b0, 4'd0, 16'h0);
    step();
    check_wr("t3_pop", 1'b1, 4'd5, 16'hBEEF);
    check("t3_busy_clr", 32'(busy), 32'h0000);

    // T4: pipe streams while two slow results queue up and starve
    set_pipe(1'b1, 4'd1, 16'h1001); set_slow(1'b1, 4'd7, 16'h7001);
    step();
    check_wr("t4_a", 1'b1, 4'd1, 16'h1001);
    set_pipe(1'b1, 4'd1, 16'h1002); set_slow(1'b1, 4'd8, 16'h8001);
    step();
    check_wr("t4_b", 1'b1, 4'd1, 16'h1002);
    check("t4_full_ready", 32'(slow_ready), 32'd0);
    set_pipe(1'b1, 4'd1, 16'h1003); set_slow(1'b1, 4'd9, 16'h9001);
    step();
    check("t4_c_hold", 32'(hold), 32'd0);
    set_pipe(1'b1, 4'd1, 16'h1004); set_slow(1'b0, 4'd0, 16'h0);
    step();
    check("t4_d_hold", 32'(hold), 32'd0);
    set_pipe(1'b1, 4'd1, 16'h1005);
    step();
    check_wr("t4_e", 1'b1, 4'd1, 16'h1005);
    check("t4_e_hold", 32'(hold), 32'd1);
    set_pipe(1'b1, 4'd1, 16'h1006);
    step();
    check_wr("t4_f_pop7", 1'b1, 4'd7, 16'h7001);
    check("t4_f_hold", 32'(hold), 32'd0);
    step(); // held pipe data re-presented
    check_wr("t4_g_repl", 1'b1, 4'd1, 16'h1006);
    set_pipe(1'b0, 4'd0, 16'h0);
    step();
    check_wr("t4_h_pop8", 1'b1, 4'd8, 16'h8001);
    check("t4_h_ready", 32'(slow_ready), 32'd1);
    step();
    check("t4_i_empty", 32'(wen), 32'd0);

    // T5: pop of r6 in the same cycle as a new issue to r6
    issue_valid = 1'b1; issue_waddr = 4'd6;
    step();
    issue_valid = 1'b0;
    set_slow(1'b1, 4'd6, 16'h6666);
    step();
    set_slow(1'b0, 4'd0, 16'h0);
    issue_valid = 1'b1; issue_waddr = 4'd6;
    step();
    check_wr("t5_pop6", 1'b1, 4'd6, 16'h6666);
    check("t5_busy_kept", 32'(busy), 32'h0040);
    issue_valid = 1'b0;

    // T6: pipe write to busy r2 pulses conflict; non-busy r3 does not
    issue_valid = 1'b1; issue_waddr = 4'd2;
    step();
    issue_valid = 1'b0;
    check("t6_busy", 32'(busy), 32'h0044);
    set_pipe(1'b1, 4'd2, 16'h2222);
    step();
    check_wr("t6_w2", 1'b1, 4'd2, 16'h2222);
    check("t6_conf", 32'(conflict), 32'd1);
    set_pipe(1'b1, 4'd3, 16'h3333);
    step();
    check("t6_conf_r3", 32'(conflict), 32'd0);
    set_pipe(1'b0, 4'd0, 16'h0);
    step();
    check("t6_conf_off", 32'(conflict), 32'd0);

    // T6 repeat: reset while FIFO holds two results
    set_pipe(1'b1, 4'd4, 16'h4001); set_slow(1'b1, 4'd2, 16'hAAAA);
    step();
    set_pipe(1'b1, 4'd4, 16'h4002); set_slow(1'b1, 4'd6, 16'hBBBB);
    step();
    check("t6r_full", 32'(slow_ready), 32'd0);
    set_pipe(1'b0, 4'd0, 16'h0); set_slow(1'b0, 4'd0, 16'h0);
    rst = 1'b1;
    step();
    check("t6r_busy", 32'(busy), 32'd0);
    check("t6r_we", 32'(wen), 32'd0);
    check("t6r_ready", 32'(slow_ready), 32'd0);
    rst = 1'b0;
    step();
    check("t6r_nowr1", 32'(wen), 32'd0);
    check("t6r_ready_up", 32'(slow_ready), 32'd1);
    step();
    check("t6r_nowr2", 32'(wen), 32'd0);
    check("t6r_hold", 32'(hold), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
